mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the array.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before each response (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  initiator request; held high until ready.
REQ-006 we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 addr  input  32  byte address; word index = addr[31:2].
REQ-008 wdata  input  32  write data; qualified by req and we.
REQ-009 ready  output  1  one-cycle completion strobe.
REQ-010 rdata  output  32  read data; valid only while ready=1.
REQ-011 err  output  1  error flag; valid only while ready=1.
REQ-012 busy  output  1  high in WAIT and RESP states.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1, the block SHALL capture addr, we, and wdata on that edge and go to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-015 A wait counter SHALL load WAIT_CYCLES-1 on capture, decrement once per cycle in WAIT, and move to RESP after the cycle in which it equals 0.
REQ-016 ready SHALL be high for exactly one cycle, in RESP, occurring WAIT_CYCLES+1 cycles after the capture edge.
REQ-017 RESP SHALL always return to IDLE on the next edge.
REQ-018 req, we, addr, and wdata SHALL be ignored in WAIT and RESP; only the captured copies are used.
REQ-019 req high in the IDLE cycle after RESP SHALL start a new transaction, giving back-to-back spacing of WAIT_CYCLES+2 cycles.
REQ-020 A request SHALL be in error if captured addr[1:0] != 0 or captured addr[31:2] >= DEPTH_WORDS.
REQ-021 An error request SHALL take the same latency as a normal one, assert err=1 with ready, drive rdata=0, and not modify the array.
REQ-022 A valid read SHALL drive rdata = array[word index] during RESP, with err=0.
REQ-023 A valid write SHALL update array[word index] with the captured wdata on the edge ending RESP.
REQ-024 During a valid write's RESP cycle, rdata SHALL show the pre-write contents (read-before-write), with err=0.
REQ-025 Outside RESP, ready=0, err=0, and rdata=0.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 The word-index compare SHALL use the full 30-bit index, with no wrap-around or aliasing into the array.

Reset
REQ-028 When reset=1 at an edge, the block SHALL enter IDLE, clear the counter and captured registers, and force ready=0, err=0, rdata=0, busy=0 from the next cycle.
REQ-029 Reset SHALL take priority over a simultaneous req.
REQ-030 Reset in WAIT or RESP SHALL abort the transaction; an aborted write SHALL NOT modify the array, and no ready SHALL follow.
REQ-031 Reset SHALL NOT clear array contents; contents SHALL be undefined until first written.

Verification
REQ-032 Write then read, WAIT_CYCLES=2:
- Stimulus: write 0x0000_0010 <- 0xDEAD_BEEF, then read 0x10.
- Response: each ready arrives 3 cycles after capture; read returns rdata=0xDEAD_BEEF, err=0.
REQ-033 Misaligned and out-of-range:
- Stimulus: write 0x0000_0012 <- 0x1234_5678, then read 0x12; then read 0x0000_0400 (word 256, DEPTH_WORDS=256).
- Response: err=1 and rdata=0 at normal latency for all three; a later read of 0x10 still returns 0xDEAD_BEEF.
REQ-034 Back-to-back requests, WAIT_CYCLES=0:
- Stimulus: req held high for reads of 0x0, 0x4, 0x8, with addr changing the cycle after each ready.
- Response: ready pulses every 2 cycles; each rdata matches its address.
REQ-035 Reset mid-write:
- Stimulus: write 0x20 <- 0xAAAA_5555, reset asserted while busy=1, then read 0x20.
- Response: no ready before reset; outputs zero after reset; read returns the prior contents, not 0xAAAA_5555.
REQ-036 Input changes during WAIT, WAIT_CYCLES=3:
- Stimulus: read 0x10, with addr changed to 0x14 during WAIT.
- Response: rdata reflects 0x10, with ready 4 cycles after capture.
REQ-037 Read-before-write:
- Stimulus: write 0x10 <- 0x0000_0001 over existing 0xDEAD_BEEF.
- Response: rdata=0xDEAD_BEEF in RESP; next read returns 0x0000_0001.

Source files
------------

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between an initiator and mem_responder
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        busy;
    modport master (output req, we, addr, wdata, input ready, rdata, err, busy);
    modport slave (input req, we, addr, wdata, output ready, rdata, err, busy);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word memory answering one request at a time after a fixed number of wait states
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    mem_responder_if.slave bus
);
    localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state;
    logic [3:0] cnt;
    logic cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic ready_q;
    logic err_q;
    logic [31:0] rdata_q;
    logic busy_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] nxt_addr;
    logic nxt_bad;
    logic cap_bad;
    logic enter_resp;
    function automatic logic bad_addr(input logic [31:0] a);
        return a[1:0] != 2'b00 || {2'b00, a[31:2]} >= 32'(DEPTH_WORDS);
    endfunction
    // With zero wait states the response is built from the live bus on the capture edge
    assign nxt_addr = state == IDLE ? bus.addr : cap_addr;
    assign nxt_bad = bad_addr(nxt_addr);
    assign cap_bad = bad_addr(cap_addr);
    assign enter_resp = (state == IDLE && bus.req && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
    assign bus.ready = ready_q;
    assign bus.err = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy = busy_q;
    // Sequencer: capture in IDLE, count wait states, one-cycle registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            cap_we <= 1'b0;
            cap_addr <= '0;
            cap_wdata <= '0;
            ready_q <= 1'b0;
            err_q <= 1'b0;
            rdata_q <= '0;
            busy_q <= 1'b0;
        end else begin
            ready_q <= enter_resp;
            err_q <= enter_resp && nxt_bad;
            rdata_q <= enter_resp && !nxt_bad ? mem[nxt_addr[IW+1:2]] : '0;
            case (state)
                IDLE: if (bus.req) begin
                    cap_we <= bus.we;
                    cap_addr <= bus.addr;
                    cap_wdata <= bus.wdata;
                    cnt <= 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
                    state <= WAIT_CYCLES == 0 ? RESP : WAIT;
                    busy_q <= 1'b1;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // Array write lands on the edge that ends RESP, so RESP shows the old word
    always_ff @(posedge clk) begin
        if (!reset && state == RESP && cap_we && !cap_bad) mem[cap_addr[IW+1:2]] <= cap_wdata;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of three mem_responder instances (2, 0 and 3 wait states)
module tb_mem_responder;
    localparam int WS[3] = '{2, 0, 3};
    localparam int DEPTH = 256;
    logic clk;
    logic reset;
    logic req[3];
    logic we[3];
    logic [31:0] addr[3];
    logic [31:0] wdata[3];
    logic ready[3];
    logic err[3];
    logic busy[3];
    logic [31:0] rdata[3];
    int total = 0;
    int bad = 0;
    int ec = 0;
    mem_responder_if bus[3] ();
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        assign bus[g].req = req[g];
        assign bus[g].we = we[g];
        assign bus[g].addr = addr[g];
        assign bus[g].wdata = wdata[g];
        assign ready[g] = bus[g].ready;
        assign err[g] = bus[g].err;
        assign busy[g] = bus[g].busy;
        assign rdata[g] = bus[g].rdata;
        mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WS[g])) u_dut (
            .clk(clk),
            .reset(reset),
            .bus(bus[g])
        );
    end
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask
    // Transaction-level model: each accepted request owns a window of WS+1 cycles
    bit pend[3];
    int cap_e[3];
    logic m_we[3];
    logic [31:0] m_addr[3];
    logic [31:0] m_wdata[3];
    logic e_ready[3];
    logic e_err[3];
    logic e_busy[3];
    logic [31:0] e_rdata[3];
    bit e_known[3];
    logic [31:0] model_mem[longint];
    function automatic bit m_bad(input logic [31:0] a);
        return a % 4 != 0 || a / 4 >= DEPTH;
    endfunction
    function automatic longint key(input int k, input logic [31:0] a);
        return longint'(k) * 64'h1_0000_0000 + longint'(a / 4);
    endfunction
    always @(posedge clk) begin
        ec++;
        for (int k = 0; k < 3; k++) begin
            e_ready[k] = 0;
            e_err[k] = 0;
            e_rdata[k] = 0;
            e_known[k] = 1;
            if (reset) pend[k] = 0;
            else if (pend[k] && ec == cap_e[k] + WS[k] + 1) begin
                if (m_we[k] && !m_bad(m_addr[k])) model_mem[key(k, m_addr[k])] = m_wdata[k];
                pend[k] = 0;
            end else if (!pend[k] && req[k]) begin
                pend[k] = 1;
                cap_e[k] = ec;
                m_we[k] = we[k];
                m_addr[k] = addr[k];
                m_wdata[k] = wdata[k];
            end
            e_busy[k] = pend[k];
            if (pend[k] && ec == cap_e[k] + WS[k]) begin
                e_ready[k] = 1;
                e_err[k] = m_bad(m_addr[k]);
                if (!e_err[k]) begin
                    if (model_mem.exists(key(k, m_addr[k]))) e_rdata[k] = model_mem[key(k, m_addr[k])];
                    else e_known[k] = 0;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (ec > 0) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("ready%0d@%0d", k, ec), 32'(ready[k]), 32'(e_ready[k]));
                check($sformatf("err%0d@%0d", k, ec), 32'(err[k]), 32'(e_err[k]));
                check($sformatf("busy%0d@%0d", k, ec), 32'(busy[k]), 32'(e_busy[k]));
                if (e_known[k]) check($sformatf("rdata%0d@%0d", k, ec), rdata[k], e_rdata[k]);
            end
        end
    end
    task automatic tx(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit hold, input bit scramble, input bit chk_rd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat, input string name);
        int lat;
        bit done;
        lat = 0;
        done = 0;
        req[k] = 1;
        we[k] = w;
        addr[k] = a;
        wdata[k] = d;
        while (!done) begin
            @(negedge clk);
            lat++;
            if (scramble && lat == 1) begin
                addr[k] = a ^ 32'h4;
                wdata[k] = ~d;
            end
            if (ready[k]) begin
                done = 1;
                check({name, " lat"}, 32'(lat), 32'(exp_lat));
                check({name, " err"}, 32'(err[k]), 32'(exp_err));
                if (chk_rd) check({name, " rdata"}, rdata[k], exp_rd);
            end else if (lat >= 40) begin
                done = 1;
                total++;
                bad++;
                $display("FAIL %s timeout inst=%0d", name, k);
            end
        end
        if (!hold) begin
            req[k] = 0;
            @(negedge clk);
        end
    endtask
    initial begin
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 0;
            we[k] = 0;
            addr[k] = 0;
            wdata[k] = 0;
        end
        repeat (2) @(negedge clk);
        check("reset ready", 32'(ready[0]), 0);
        check("reset busy", 32'(busy[2]), 0);
        reset = 0;
        @(negedge clk);
        tx(0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 3, "w10");
        tx(0, 0, 32'h10, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 3, "r10");
        tx(0, 1, 32'h12, 32'h1234_5678, 0, 0, 1, 0, 1, 3, "w12 misaligned");
        tx(0, 0, 32'h12, 0, 0, 0, 1, 0, 1, 3, "r12 misaligned");
        tx(0, 0, 32'h400, 0, 0, 0, 1, 0, 1, 3, "r400 range");
        tx(0, 0, 32'h10, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 3, "r10 after err");
        tx(0, 1, 32'h10, 32'h1, 0, 0, 1, 32'hDEAD_BEEF, 0, 3, "w10 rbw");
        tx(0, 0, 32'h10, 0, 0, 0, 1, 32'h1, 0, 3, "r10 new");
        tx(0, 1, 32'h3FC, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 3, "w3fc last");
        tx(0, 0, 32'h3FC, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 3, "r3fc last");
        tx(0, 1, 32'h410, 32'h0BAD_0BAD, 0, 0, 1, 0, 1, 3, "w410 alias");
        tx(0, 1, 32'h4000_0010, 32'h0BAD_0BAD, 0, 0, 1, 0, 1, 3, "w40000010 alias");
        tx(0, 0, 32'h10, 0, 0, 0, 1, 32'h1, 0, 3, "r10 no alias");
        tx(1, 1, 32'h0, 32'hA0A0_0000, 0, 0, 0, 0, 0, 1, "w0 w0");
        tx(1, 1, 32'h4, 32'hB0B0_0004, 0, 0, 0, 0, 0, 1, "w0 w4");
        tx(1, 1, 32'h8, 32'hC0C0_0008, 0, 0, 0, 0, 0, 1, "w0 w8");
        tx(1, 0, 32'h0, 0, 1, 0, 1, 32'hA0A0_0000, 0, 1, "b2b r0");
        tx(1, 0, 32'h4, 0, 1, 0, 1, 32'hB0B0_0004, 0, 2, "b2b r4");
        tx(1, 0, 32'h8, 0, 0, 0, 1, 32'hC0C0_0008, 0, 2, "b2b r8");
        tx(0, 1, 32'h20, 32'h1111_2222, 0, 0, 0, 0, 0, 3, "w20 prior");
        req[0] = 1;
        we[0] = 1;
        addr[0] = 32'h20;
        wdata[0] = 32'hAAAA_5555;
        @(negedge clk);
        check("abort busy", 32'(busy[0]), 1);
        check("abort ready", 32'(ready[0]), 0);
        req[0] = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("post reset busy", 32'(busy[0]), 0);
        check("post reset ready", 32'(ready[0]), 0);
        check("post reset rdata", rdata[0], 0);
        @(negedge clk);
        tx(0, 0, 32'h20, 0, 0, 0, 1, 32'h1111_2222, 0, 3, "r20 after abort");
        tx(2, 1, 32'h10, 32'h0000_1010, 0, 0, 0, 0, 0, 4, "w3 w10");
        tx(2, 1, 32'h14, 32'h0000_1414, 0, 0, 0, 0, 0, 4, "w3 w14");
        tx(2, 0, 32'h10, 0, 0, 1, 1, 32'h0000_1010, 0, 4, "w3 r10 scrambled");
        tx(2, 0, 32'h14, 0, 0, 0, 1, 32'h0000_1414, 0, 4, "w3 r14");
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
